// File: rtl/switch_io_pkg.sv
// Shared register-map constants and address decode helper for the switch input peripheral.
package switch_io_pkg;

    localparam int unsigned WINDOW_BYTES = 16;

    localparam logic [3:0] OFF_VALUE = 4'h0;
    localparam logic [3:0] OFF_RAW   = 4'h4;
    localparam logic [3:0] OFF_FLAGS = 4'h8;
    localparam logic [3:0] OFF_MASK  = 4'hC;

    typedef enum logic [1:0] {
        REG_VALUE,
        REG_RAW,
        REG_FLAGS,
        REG_MASK
    } reg_sel_e;

    // Byte lanes inside a word are irrelevant, so only offset bits [3:2] select a register.
    function automatic reg_sel_e decode_reg(input logic [3:0] off);
        reg_sel_e sel;
        case ({off[3:2], 2'b00})
            OFF_VALUE: sel = REG_VALUE;
            OFF_RAW:   sel = REG_RAW;
            OFF_FLAGS: sel = REG_FLAGS;
            OFF_MASK:  sel = REG_MASK;
            default:   sel = REG_VALUE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a stability counter.
// The debounced output only follows the synchronised input after DB_CYCLES consecutive differing samples.
module sw_debounce_bit #(
    parameter int DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic sync,
    output logic toggle
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;
    logic          differ;
    logic          expire;

    assign differ = sync_q[1] ^ db_q;
    assign expire = differ && (cnt_q == CW'(DB_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in};
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                cnt_q <= '0;
                db_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out    = db_q;
    assign sync   = sync_q[1];
    assign toggle = expire;

endmodule

// File: rtl/switch_io_ctrl.sv
// Memory-mapped debounced switch input peripheral with sticky W1C change flags.
// Define SWITCH_IRQ_EN to add the MASK register and a registered change interrupt.
module switch_io_ctrl
    import switch_io_pkg::*;
#(
    parameter int          SW_WIDTH  = 24,
    parameter int          DB_CYCLES = 20,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_F070
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic [31:0]         addr,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [31:0]         wdata,
    output logic [31:0]         data,
    output logic                irq
);

    logic [SW_WIDTH-1:0] db;
    logic [SW_WIDTH-1:0] sync_v;
    logic [SW_WIDTH-1:0] toggle;
    logic [SW_WIDTH-1:0] flag_q;
    logic [SW_WIDTH-1:0] flag_clr;
    logic [31:0]         data_q;
    logic [31:0]         rdata_d;
    logic                in_win;
    logic                wr_hit;
    reg_sel_e            sel;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        sw_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .in     (sw[i]),
            .out    (db[i]),
            .sync   (sync_v[i]),
            .toggle (toggle[i])
        );
    end

    // The window is WINDOW_BYTES aligned, so only the bits above the offset take part in the match.
    assign in_win   = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel      = decode_reg(addr[3:0]);
    assign wr_hit   = in_win && wr_en;
    assign flag_clr = (wr_hit && sel == REG_FLAGS) ? wdata[SW_WIDTH-1:0] : '0;

`ifdef SWITCH_IRQ_EN
    logic [SW_WIDTH-1:0] mask_q;
    logic                irq_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_hit && sel == REG_MASK) begin
                mask_q <= wdata[SW_WIDTH-1:0];
            end
            irq_q <= |(flag_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        if (in_win) begin
            case (sel)
                REG_VALUE: rdata_d = 32'(db);
                REG_RAW:   rdata_d = 32'(sync_v);
                REG_FLAGS: rdata_d = 32'(flag_q);
`ifdef SWITCH_IRQ_EN
                REG_MASK:  rdata_d = 32'(mask_q);
`endif
                default:   rdata_d = '0;
            endcase
        end
    end

    // A toggle in the same cycle as a W1C of that bit keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            flag_q <= '0;
            data_q <= '0;
        end else begin
            flag_q <= (flag_q & ~flag_clr) | toggle;
            if (rd_en) begin
                data_q <= rdata_d;
            end
        end
    end

    assign data = data_q;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

endmodule
